writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port ex_valid, input, 1, execute requester has a result.
REQ-004 SHALL have port ex_ready, output, 1, execute result consumed this cycle.
REQ-005 SHALL have ports ex_data (input, 64) and ex_addr (input, 5), execute result and destination.
REQ-006 SHALL have ports ex_regwrite, ex_setflags and ex_branch (inputs, 1 each), execute control.
REQ-007 SHALL have port ex_flags, input, 4, NZCV from execute.
REQ-008 SHALL have port mem_valid, input, 1, memory requester has a result.
REQ-009 SHALL have port mem_ready, output, 1, memory result consumed this cycle.
REQ-010 SHALL have ports mem_data (input, 64), mem_addr (input, 5) and mem_regwrite (input, 1).
REQ-011 SHALL have port flush, input, 1, discard execute-side results.
REQ-012 SHALL have port wb_stall, input, 1, register file cannot accept a write.
REQ-013 SHALL have outputs write_data (64), write_addr (5), regwrite (1), setflags (1), flags (4) and branch (1), registered writeback port.

Function
REQ-014 SHALL grant at most one requester per cycle; a grant requires the requester's valid=1, wb_stall=0 and, for execute, flush=0.
REQ-015 SHALL arbitrate round-robin with a 1-bit priority pointer: if both requesters are eligible, grant the pointed one; if only one is eligible, grant it.
REQ-016 SHALL set the pointer to the non-granted requester after every grant; with no grant, the pointer holds.
REQ-017 SHALL drive ex_ready/mem_ready combinationally: 1 when granted, else 0, except REQ-020.
REQ-018 SHALL, one cycle after a grant, present the granted fields on the outputs (1-cycle latency); a memory grant drives setflags=0, branch=0, flags=0.
REQ-019 SHALL force regwrite=0 when the granted address is 31 (zero register); the grant is still consumed, and setflags/branch still apply.
REQ-020 SHALL, when flush=1 and ex_valid=1, assert ex_ready and drop the execute result with no output effect; this holds even when wb_stall=1.
REQ-021 SHALL, when flush=1, still grant an eligible memory request in the same cycle.
REQ-022 SHALL, when wb_stall=1, hold every output register and the pointer, and drive mem_ready=0 and ex_ready=0 (except REQ-020).
REQ-023 SHALL, on a cycle with wb_stall=0 and no grant, drive regwrite, setflags and branch to 0 on the next cycle while write_data, write_addr and flags hold.
REQ-024 SHALL, when a requester keeps valid high, present the same result until it is granted (requesters obey valid-hold; the block does not check this).

Reset
REQ-025 SHALL, when rst=1 at a rising edge, clear write_data, write_addr, regwrite, setflags, flags and branch to 0, and the pointer to execute.
REQ-026 SHALL drive ex_ready=0 and mem_ready=0 while rst=1, regardless of flush.
REQ-027 SHALL discard, with no output effect, any grant that coincides with reset; rst overrides flush and wb_stall.

Configuration
REQ-028 SHALL, with WB_COMMIT_CNT_EN defined, provide output commit_count (16 bits, reset 0), incremented once per grant (dropped flush results excluded) and wrapping from 0xFFFF to 0x0000.
REQ-029 SHALL, without WB_COMMIT_CNT_EN, omit the commit_count port and its logic, with all other behaviour identical.

Verification
REQ-030 SHALL cover contention: ex and mem valid in 4 consecutive cycles after reset -> grants ex, mem, ex, mem; each result appears on the outputs one cycle after its grant.
REQ-031 SHALL cover the zero register: ex grant with ex_addr=31, ex_regwrite=1, ex_setflags=1, ex_flags=4'b0100 -> next cycle regwrite=0, setflags=1, flags=4'b0100.
REQ-032 SHALL cover flush: flush=1 with ex_valid=1 and mem_valid=1 (mem_addr=5, mem_data=0xDEAD) -> ex_ready=1, mem_ready=1; next cycle write_addr=5, write_data=0xDEAD, setflags=0.
REQ-033 SHALL cover stall: wb_stall=1 for 3 cycles with both requesters valid -> outputs frozen and both ready=0; on release, grant follows the pointer held from before the stall.
REQ-034 SHALL cover mid-operation reset: rst=1 in the same cycle as an ex grant -> next cycle all outputs are 0 and the next contention grants ex first.
REQ-035 SHALL cover counter wrap (with WB_COMMIT_CNT_EN): 65536 grants -> commit_count returns to 0; flushed ex results do not increment it.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Two-requester writeback arbiter (execute, memory) with a registered register-file port.
// Optional commit counter enabled by defining WB_COMMIT_CNT_EN.
module writeback_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [63:0] ex_data,
  input  logic [4:0]  ex_addr,
  input  logic        ex_regwrite,
  input  logic        ex_setflags,
  input  logic        ex_branch,
  input  logic [3:0]  ex_flags,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [63:0] mem_data,
  input  logic [4:0]  mem_addr,
  input  logic        mem_regwrite,
  input  logic        flush,
  input  logic        wb_stall,
  output logic [63:0] write_data,
  output logic [4:0]  write_addr,
  output logic        regwrite,
  output logic        setflags,
  output logic [3:0]  flags,
  output logic        branch
`ifdef WB_COMMIT_CNT_EN
  ,
  output logic [15:0] commit_count
`endif
);

  localparam int          DATA_W   = 64;
  localparam logic [4:0]  ZERO_REG = 5'd31;

  typedef enum logic {
    PTR_EX  = 1'b0,
    PTR_MEM = 1'b1
  } ptr_e;

  ptr_e              ptr_q, ptr_d;
  logic              ex_elig, mem_elig;
  logic              grant_ex, grant_mem;

  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [4:0]        write_addr_q, write_addr_d;
  logic              regwrite_q, regwrite_d;
  logic              setflags_q, setflags_d;
  logic [3:0]        flags_q, flags_d;
  logic              branch_q, branch_d;

  // Writes to the zero register are consumed but never reach the register file.
  function automatic logic qualify_regwrite(input logic rw, input logic [4:0] addr);
    return rw && (addr != ZERO_REG);
  endfunction

  always_comb begin
    ex_elig   = ex_valid  && !wb_stall && !flush && !rst;
    mem_elig  = mem_valid && !wb_stall && !rst;
    grant_ex  = ex_elig  && (!mem_elig || (ptr_q == PTR_EX));
    grant_mem = mem_elig && (!ex_elig  || (ptr_q == PTR_MEM));
  end

  // A flushed execute result is acknowledged and dropped, even while stalled.
  always_comb begin
    ex_ready  = !rst && (grant_ex || (flush && ex_valid));
    mem_ready = grant_mem;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_ex) begin
      ptr_d = PTR_MEM;
    end else if (grant_mem) begin
      ptr_d = PTR_EX;
    end
  end

  always_comb begin
    write_data_d = write_data_q;
    write_addr_d = write_addr_q;
    regwrite_d   = regwrite_q;
    setflags_d   = setflags_q;
    flags_d      = flags_q;
    branch_d     = branch_q;
    if (!wb_stall) begin
      regwrite_d = 1'b0;
      setflags_d = 1'b0;
      branch_d   = 1'b0;
      if (grant_ex) begin
        write_data_d = ex_data;
        write_addr_d = ex_addr;
        regwrite_d   = qualify_regwrite(ex_regwrite, ex_addr);
        setflags_d   = ex_setflags;
        flags_d      = ex_flags;
        branch_d     = ex_branch;
      end else if (grant_mem) begin
        write_data_d = mem_data;
        write_addr_d = mem_addr;
        regwrite_d   = qualify_regwrite(mem_regwrite, mem_addr);
        flags_d      = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= PTR_EX;
      write_data_q <= '0;
      write_addr_q <= '0;
      regwrite_q   <= 1'b0;
      setflags_q   <= 1'b0;
      flags_q      <= '0;
      branch_q     <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      write_data_q <= write_data_d;
      write_addr_q <= write_addr_d;
      regwrite_q   <= regwrite_d;
      setflags_q   <= setflags_d;
      flags_q      <= flags_d;
      branch_q     <= branch_d;
    end
  end

  assign write_data = write_data_q;
  assign write_addr = write_addr_q;
  assign regwrite   = regwrite_q;
  assign setflags   = setflags_q;
  assign flags      = flags_q;
  assign branch     = branch_q;

`ifdef WB_COMMIT_CNT_EN
  logic [15:0] commit_count_q, commit_count_d;

  // Only real grants count; flushed execute results never produce a grant.
  always_comb begin
    commit_count_d = commit_count_q;
    if (grant_ex || grant_mem) begin
      commit_count_d = commit_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_count_q <= '0;
    end else begin
      commit_count_q <= commit_count_d;
    end
  end

  assign commit_count = commit_count_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: contention, zero register, flush, stall, reset
// and (with WB_COMMIT_CNT_EN) commit counter wrap.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_data;
  logic [4:0]  ex_addr;
  logic        ex_regwrite, ex_setflags, ex_branch;
  logic [3:0]  ex_flags;
  logic        mem_valid, mem_ready;
  logic [63:0] mem_data;
  logic [4:0]  mem_addr;
  logic        mem_regwrite;
  logic        flush, wb_stall;
  logic [63:0] write_data;
  logic [4:0]  write_addr;
  logic        regwrite, setflags, branch;
  logic [3:0]  flags;
`ifdef WB_COMMIT_CNT_EN
  logic [15:0] commit_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_data(ex_data), .ex_addr(ex_addr),
    .ex_regwrite(ex_regwrite), .ex_setflags(ex_setflags), .ex_branch(ex_branch),
    .ex_flags(ex_flags),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
    .mem_addr(mem_addr), .mem_regwrite(mem_regwrite),
    .flush(flush), .wb_stall(wb_stall),
    .write_data(write_data), .write_addr(write_addr), .regwrite(regwrite),
    .setflags(setflags), .flags(flags), .branch(branch)
`ifdef WB_COMMIT_CNT_EN
    , .commit_count(commit_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [63:0] d, input logic [4:0] a,
                        input logic rw, input logic sf, input logic br, input logic [3:0] f);
    ex_valid = v; ex_data = d; ex_addr = a;
    ex_regwrite = rw; ex_setflags = sf; ex_branch = br; ex_flags = f;
  endtask

  task automatic set_mem(input logic v, input logic [63:0] d, input logic [4:0] a,
                         input logic rw);
    mem_valid = v; mem_data = d; mem_addr = a; mem_regwrite = rw;
  endtask

  task automatic check_out(input string tag, input logic [63:0] d, input logic [4:0] a,
                           input logic rw, input logic sf, input logic [3:0] f, input logic br);
    check({tag, ".data"},     write_data, d);
    check({tag, ".addr"},     {59'd0, write_addr}, {59'd0, a});
    check({tag, ".regwrite"}, {63'd0, regwrite}, {63'd0, rw});
    check({tag, ".setflags"}, {63'd0, setflags}, {63'd0, sf});
    check({tag, ".flags"},    {60'd0, flags}, {60'd0, f});
    check({tag, ".branch"},   {63'd0, branch}, {63'd0, br});
  endtask

  task automatic check_rdy(input string tag, input logic er, input logic mr);
    #1;
    check({tag, ".ex_ready"},  {63'd0, ex_ready},  {63'd0, er});
    check({tag, ".mem_ready"}, {63'd0, mem_ready}, {63'd0, mr});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b1; wb_stall = 1'b0;
    set_ex(1'b1, 64'h1, 5'd1, 1'b1, 1'b1, 1'b1, 4'hF);
    set_mem(1'b1, 64'h2, 5'd2, 1'b1);
    #1;
    check_rdy("rst_ready", 1'b0, 1'b0);
    tick();
    tick();
    check_out("reset", 64'h0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0);
`ifdef WB_COMMIT_CNT_EN
    check("reset.count", {48'd0, commit_count}, 64'd0);
`endif
    rst = 1'b0; flush = 1'b0;

    // Contention: ex, mem, ex, mem.
    set_ex(1'b1, 64'h11, 5'd1, 1'b1, 1'b0, 1'b0, 4'h0);
    set_mem(1'b1, 64'h22, 5'd2, 1'b1);
    check_rdy("cont1", 1'b1, 1'b0);
    tick();
    check_out("cont1", 64'h11, 5'd1, 1'b1, 1'b0, 4'h0, 1'b0);
    set_ex(1'b1, 64'h13, 5'd3, 1'b1, 1'b1, 1'b1, 4'hA);
    check_rdy("cont2", 1'b0, 1'b1);
    tick();
    check_out("cont2", 64'h22, 5'd2, 1'b1, 1'b0, 4'h0, 1'b0);
    set_mem(1'b1, 64'h24, 5'd4, 1'b0);
    check_rdy("cont3", 1'b1, 1'b0);
    tick();
    check_out("cont3", 64'h13, 5'd3, 1'b1, 1'b1, 4'hA, 1'b1);
    set_ex(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'h0);
    check_rdy("cont4", 1'b0, 1'b1);
    tick();
    check_out("cont4", 64'h24, 5'd4, 1'b0, 1'b0, 4'h0, 1'b0);

    // Idle after an ex grant with flags: strobes drop, data/addr/flags hold.
    set_mem(1'b0, 64'h0, 5'd0, 1'b0);
    set_ex(1'b1, 64'h31, 5'd6, 1'b1, 1'b1, 1'b1, 4'h9);
    check_rdy("pre_idle", 1'b1, 1'b0);
    tick();
    set_ex(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'h0);
    check_rdy("idle", 1'b0, 1'b0);
    tick();
    check_out("idle", 64'h31, 5'd6, 1'b0, 1'b0, 4'h9, 1'b0);

    // Zero register: ptr is MEM now but only ex is valid.
    set_ex(1'b1, 64'h55, 5'd31, 1'b1, 1'b1, 1'b0, 4'b0100);
    check_rdy("zreg", 1'b1, 1'b0);
    tick();
    check_out("zreg", 64'h55, 5'd31, 1'b0, 1'b1, 4'b0100, 1'b0);

    // Flush: ex dropped, mem granted in the same cycle.
    flush = 1'b1;
    set_ex(1'b1, 64'h66, 5'd6, 1'b1, 1'b1, 1'b1, 4'hF);
    set_mem(1'b1, 64'hDEAD, 5'd5, 1'b1);
    check_rdy("flush", 1'b1, 1'b1);
    tick();
    check_out("flush", 64'hDEAD, 5'd5, 1'b1, 1'b0, 4'h0, 1'b0);

    // Flush during stall: ex still acknowledged, outputs frozen.
    wb_stall = 1'b1;
    set_mem(1'b0, 64'h0, 5'd0, 1'b0);
    check_rdy("flush_stall", 1'b1, 1'b0);
    tick();
    check_out("flush_stall", 64'hDEAD, 5'd5, 1'b1, 1'b0, 4'h0, 1'b0);
    flush = 1'b0;

    // Make ptr point at MEM before the stall, so the release must grant mem first.
    wb_stall = 1'b0;
    set_ex(1'b1, 64'h44, 5'd4, 1'b1, 1'b0, 1'b0, 4'h0);
    check_rdy("pre_stall", 1'b1, 1'b0);
    tick();
    check_out("pre_stall", 64'h44, 5'd4, 1'b1, 1'b0, 4'h0, 1'b0);

    wb_stall = 1'b1;
    set_ex(1'b1, 64'h77, 5'd7, 1'b1, 1'b0, 1'b1, 4'h3);
    set_mem(1'b1, 64'h88, 5'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_rdy($sformatf("stall%0d", i), 1'b0, 1'b0);
      tick();
      check_out($sformatf("stall%0d", i), 64'h44, 5'd4, 1'b1, 1'b0, 4'h0, 1'b0);
    end
    wb_stall = 1'b0;
    check_rdy("release1", 1'b0, 1'b1);
    tick();
    check_out("release1", 64'h88, 5'd8, 1'b1, 1'b0, 4'h0, 1'b0);
    set_mem(1'b0, 64'h0, 5'd0, 1'b0);
    check_rdy("release2", 1'b1, 1'b0);
    tick();
    check_out("release2", 64'h77, 5'd7, 1'b1, 1'b0, 4'h3, 1'b1);

    // ptr now MEM; reset with a would-be ex grant must clear it back to EX.
    rst = 1'b1;
    set_ex(1'b1, 64'h99, 5'd9, 1'b1, 1'b1, 1'b1, 4'h5);
    check_rdy("midrst", 1'b0, 1'b0);
    tick();
    check_out("midrst", 64'h0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    set_mem(1'b1, 64'hAA, 5'd10, 1'b1);
    check_rdy("postrst", 1'b1, 1'b0);
    tick();
    check_out("postrst", 64'h99, 5'd9, 1'b1, 1'b1, 4'h5, 1'b1);

`ifdef WB_COMMIT_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wrap.start", {48'd0, commit_count}, 64'd0);
    flush = 1'b1;
    set_ex(1'b1, 64'h1, 5'd1, 1'b1, 1'b0, 1'b0, 4'h0);
    set_mem(1'b0, 64'h0, 5'd0, 1'b0);
    tick();
    check("wrap.flushed", {48'd0, commit_count}, 64'd0);
    flush = 1'b0;
    set_ex(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'h0);
    set_mem(1'b1, 64'h3, 5'd3, 1'b1);
    for (int i = 0; i < 65535; i++) tick();
    check("wrap.ffff", {48'd0, commit_count}, 64'hFFFF);
    tick();
    check("wrap.zero", {48'd0, commit_count}, 64'd0);
    set_mem(1'b0, 64'h0, 5'd0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
